// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Fixed 33-edge latency from accept to out_valid, valid/ready handshake on both sides.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      MDop,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Out,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] x, input logic en);
    cond_neg = en ? (~x + {{(XLEN-1){1'b0}}, 1'b1}) : x;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] x, input logic en);
    cond_neg2 = en ? (~x + {{(2*XLEN-1){1'b0}}, 1'b1}) : x;
  endfunction

  state_t                state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [2:0]            op_r;
  logic [XLEN-1:0]       a_r;
  logic [XLEN-1:0]       opnd_r;
  logic [2*XLEN-1:0]     acc_r;
  logic                  neg_r;
  logic                  div0_r;

  logic                  sa_s;
  logic                  sb_s;
  logic [XLEN-1:0]       mag_a_s;
  logic [XLEN-1:0]       mag_b_s;
  logic [XLEN:0]         mul_sum_s;
  logic [XLEN+1:0]       div_diff_s;
  logic [2*XLEN-1:0]     step_s;
  logic [2*XLEN-1:0]     prod_s;
  logic [XLEN-1:0]       qr_s;
  logic [XLEN-1:0]       result_s;

  // Operand sign extraction and magnitude conversion on the request inputs.
  always_comb begin
    sa_s    = A[XLEN-1] & ((~MDop[2] & ((MDop[1:0] == 2'd1) | (MDop[1:0] == 2'd2)))
                           | (MDop[2] & ~MDop[0]));
    sb_s    = B[XLEN-1] & ((MDop == 3'd1) | (MDop[2] & ~MDop[0]));
    mag_a_s = cond_neg(A, sa_s);
    mag_b_s = cond_neg(B, sb_s);
  end

  // One datapath iteration: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
    div_diff_s = {1'b0, acc_r[2*XLEN-1:XLEN-1]} - {2'b00, opnd_r};
    if (op_r[2]) begin
      if (!div_diff_s[XLEN+1]) begin
        step_s = {div_diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
      end else begin
        step_s = {acc_r[2*XLEN-2:0], 1'b0};
      end
    end else begin
      step_s = {mul_sum_s, acc_r[XLEN-1:1]};
    end
  end

  // Sign fix-up and special-case selection of the final result.
  always_comb begin
    prod_s = cond_neg2(acc_r, neg_r);
    qr_s   = cond_neg(op_r[1] ? acc_r[2*XLEN-1:XLEN] : acc_r[XLEN-1:0], neg_r);
    if (!op_r[2]) begin
      result_s = (op_r == 3'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end else if (div0_r) begin
      result_s = op_r[1] ? a_r : {XLEN{1'b1}};
    end else begin
      result_s = qr_s;
    end
  end

  // Control FSM with registered handshake outputs; flush outranks accept and completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      op_r      <= 3'd0;
      a_r       <= {XLEN{1'b0}};
      opnd_r    <= {XLEN{1'b0}};
      acc_r     <= {(2*XLEN){1'b0}};
      neg_r     <= 1'b0;
      div0_r    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      Out       <= {XLEN{1'b0}};
    end else if (flush) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            state_r  <= CALC;
            cnt_r    <= {CNT_W{1'b0}};
            op_r     <= MDop;
            a_r      <= A;
            opnd_r   <= MDop[2] ? mag_b_s : mag_a_s;
            acc_r    <= {{XLEN{1'b0}}, (MDop[2] ? mag_a_s : mag_b_s)};
            neg_r    <= (MDop[2] & MDop[1]) ? sa_s : (sa_s ^ sb_s);
            div0_r   <= (B == {XLEN{1'b0}});
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end else begin
            state_r  <= IDLE;
          end
        end
        CALC: begin
          if (cnt_r == CNT_W'(XLEN)) begin
            state_r   <= DONE;
            Out       <= result_s;
            out_valid <= 1'b1;
          end else begin
            acc_r <= step_s;
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r   <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end else begin
            state_r   <= DONE;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
